uart_tx_frame_fsm: RTL

UART transmit framing engine, directly downstream of the 16x transmit sample counter. It latches a byte on Tx_WR and serialises start, data (LSB first), optional parity and stop bits onto TxD. Each bit lasts exactly 16 sample_ENABLE pulses. A bit boundary is the cycle where sample_ENABLE=1 and trans_counter=15. The counter is cleared by the same Tx_WR, so framing and counter stay aligned.

---
 rtl/uart_tx_frame_fsm_if.sv | 34 +++
 rtl/uart_tx_frame_fsm.sv | 124 ++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_fsm_if.sv
// UART transmit framing bus: host strobe/data, baud tick and counter in,
// serial line and status out.
interface uart_tx_frame_fsm_if;
    logic       Tx_EN;
    logic       Tx_WR;
    logic [7:0] Tx_DATA;
    logic       sample_ENABLE;
    logic [3:0] trans_counter;
    logic       TxD;
    logic       Tx_BUSY;
    logic       Tx_DONE;

    modport master (
        output Tx_EN,
        output Tx_WR,
        output Tx_DATA,
        output sample_ENABLE,
        output trans_counter,
        input  TxD,
        input  Tx_BUSY,
        input  Tx_DONE
    );

    modport slave (
        input  Tx_EN,
        input  Tx_WR,
        input  Tx_DATA,
        input  sample_ENABLE,
        input  trans_counter,
        output TxD,
        output Tx_BUSY,
        output Tx_DONE
    );
endinterface

// File: rtl/uart_tx_frame_fsm.sv
// UART transmit framing FSM: start, LSB-first data, optional parity, stop.
// Bit boundaries come from the external 16x sample counter.
module uart_tx_frame_fsm #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input logic             clk,
    input logic             reset,
    uart_tx_frame_fsm_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [7:0] DATA_MASK = 8'hFF >> (8 - DATA_BITS);
    localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);
    localparam logic       PAR_ODD   = 1'(PARITY_ODD);

    state_t     r_state;
    logic [7:0] r_shift;
    logic [2:0] r_idx;
    logic       r_par;
    logic       r_stop;
    logic       r_txd;
    logic       r_busy;
    logic       r_done;

    logic       w_tick;
    logic       w_accept;
    logic [2:0] w_nxt_idx;
    logic       w_par;
    logic       w_last_stop;

    assign w_tick    = bus.sample_ENABLE & (bus.trans_counter == 4'd15);
    // The Tx_DONE cycle is already IDLE in state but still counts as busy.
    assign w_accept  = bus.Tx_WR & bus.Tx_EN & ~r_done;
    assign w_nxt_idx = r_idx + 3'd1;
    assign w_par     = (^(bus.Tx_DATA & DATA_MASK)) ^ PAR_ODD;
    assign w_last_stop = (STOP_BITS == 2) ? r_stop : 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_shift <= 8'd0;
            r_idx   <= 3'd0;
            r_par   <= 1'b0;
            r_stop  <= 1'b0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_START;
                        r_shift <= bus.Tx_DATA;
                        r_par   <= w_par;
                        r_idx   <= 3'd0;
                        r_stop  <= 1'b0;
                        r_txd   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_state <= S_DATA;
                        r_txd   <= r_shift[0];
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_idx == LAST_IDX) begin
                            if (PARITY_EN != 0) begin
                                r_state <= S_PARITY;
                                r_txd   <= r_par;
                            end else begin
                                r_state <= S_STOP;
                                r_txd   <= 1'b1;
                            end
                        end else begin
                            r_idx <= w_nxt_idx;
                            r_txd <= r_shift[w_nxt_idx];
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        r_state <= S_STOP;
                        r_txd   <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (w_last_stop) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_stop <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.TxD     = r_txd;
    assign bus.Tx_BUSY = r_busy;
    assign bus.Tx_DONE = r_done;

endmodule
